// File: rtl/btn_debounce_bank.sv
// N-channel push-button conditioner: 2-FF synchroniser, tick-sampled debounce, press strobe.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module btn_debounce_bank #(
  parameter int N_CH         = 4,
  parameter int TICK_CLOCKS  = 5000000,
  parameter int STABLE_TICKS = 2,
  parameter int HOLD_TICKS   = 20,
  parameter int REPEAT_TICKS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            tick
);

  localparam int TW = (TICK_CLOCKS > 2) ? $clog2(TICK_CLOCKS) : 1;
  localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CLOCKS - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick_q, tick_d;
  logic [N_CH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] pulse_q, pulse_d;
  logic [N_CH-1:0] rep_pulse;
  logic [SW-1:0]   stab_q [N_CH];
  logic [SW-1:0]   stab_d [N_CH];

  // Free-running sample tick generator and input synchroniser next-state
  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
    tick_d = (tick_cnt_d == TICK_LAST);
    s1_d   = btn_in;
    s2_d   = s1_q;
  end

  // Per-channel debounce: level flips only after STABLE_TICKS consecutive differing samples
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      stab_d[i] = stab_q[i];
      if (tick_q) begin
        if (s2_q[i] == level_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == STABLE_LAST) begin
          level_d[i] = s2_q[i];
          stab_d[i]  = '0;
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
      end else begin
        stab_d[i] = stab_q[i];
      end
      pulse_d[i] = (level_d[i] & ~level_q[i]) | rep_pulse[i];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_FULL  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_TICKS - 1);

  logic [HW-1:0] hold_q [N_CH];
  logic [HW-1:0] hold_d [N_CH];
  logic [RW-1:0] rep_q  [N_CH];
  logic [RW-1:0] rep_d  [N_CH];

  // Hold counter saturates at HOLD_TICKS; repeat counter then paces further pulses
  always_comb begin
    rep_pulse = '0;
    for (int i = 0; i < N_CH; i++) begin
      hold_d[i] = hold_q[i];
      rep_d[i]  = rep_q[i];
      if (!level_d[i]) begin
        hold_d[i] = '0;
        rep_d[i]  = '0;
      end else if (tick_q && level_q[i]) begin
        if (hold_q[i] == HOLD_FULL) begin
          if (rep_q[i] == REP_LAST) begin
            rep_d[i]     = '0;
            rep_pulse[i] = 1'b1;
          end else begin
            rep_d[i] = rep_q[i] + RW'(1);
          end
        end else if (hold_q[i] == HOLD_LAST) begin
          hold_d[i]    = HOLD_FULL;
          rep_pulse[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  // Hold/repeat counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        hold_q[i] <= '0;
        rep_q[i]  <= '0;
      end else begin
        hold_q[i] <= hold_d[i];
        rep_q[i]  <= rep_d[i];
      end
    end
  end
`else
  assign rep_pulse = '0;
`endif

  // State registers; reset overrides every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      level_q    <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < N_CH; i++) stab_q[i] <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < N_CH; i++) stab_q[i] <= stab_d[i];
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign tick  = tick_q;

endmodule
